// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one DPRAM controller command port between two requesters.
// One command in flight at a time; per-port done/err/rdata are returned to the owner.
module dpram_port_arbiter #(
   parameter int unsigned AW      = 10,
   parameter int unsigned DW      = 16,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          ar,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          done0,
   output logic          done1,
   output logic          err0,
   output logic          err1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic [AW-1:0] mem_a,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout,
   input  logic          mem_done,
   output logic          busy
);

   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e        state_q, state_d;
   logic          ptr_q, ptr_d;
   logic          owner_q, owner_d;
   logic          we_q, we_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] mem_a_q, mem_a_d;
   logic [DW-1:0] mem_din_q, mem_din_d;
   logic [DW-1:0] rdata0_q, rdata0_d;
   logic [DW-1:0] rdata1_q, rdata1_d;
   logic          gnt0_q, gnt0_d;
   logic          gnt1_q, gnt1_d;
   logic          done0_q, done0_d;
   logic          done1_q, done1_d;
   logic          err0_q, err0_d;
   logic          err1_q, err1_d;
   logic          mem_rd_q, mem_rd_d;
   logic          mem_wr_q, mem_wr_d;
   logic          win;
   logic          win_we;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      we_d      = we_q;
      cnt_d     = cnt_q;
      mem_a_d   = mem_a_q;
      mem_din_d = mem_din_q;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;
      gnt0_d    = gnt0_q;
      gnt1_d    = gnt1_q;
      done0_d   = 1'b0;
      done1_d   = 1'b0;
      err0_d    = 1'b0;
      err1_d    = 1'b0;
      mem_rd_d  = 1'b0;
      mem_wr_d  = 1'b0;
      win       = 1'b0;
      win_we    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               // Contention is settled by ptr; a lone requester always wins.
               win       = (req0 && req1) ? ptr_q : req1;
               win_we    = win ? we1 : we0;
               owner_d   = win;
               we_d      = win_we;
               mem_a_d   = win ? addr1 : addr0;
               mem_din_d = win ? wdata1 : wdata0;
               gnt0_d    = ~win;
               gnt1_d    = win;
               mem_wr_d  = win_we;
               mem_rd_d  = ~win_we;
               state_d   = StIssue;
            end
         end
         StIssue: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            if (mem_done) begin
               state_d = StResp;
               done0_d = ~owner_q;
               done1_d = owner_q;
               if (!we_q) begin
                  if (owner_q) rdata1_d = mem_dout;
                  else         rdata0_d = mem_dout;
               end
            end else if (cnt_q == CntLast) begin
               state_d = StResp;
               done0_d = ~owner_q;
               done1_d = owner_q;
               err0_d  = ~owner_q;
               err1_d  = owner_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StResp: begin
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            ptr_d   = ~owner_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (ar) begin
         state_q   <= StIdle;
         ptr_q     <= 1'b0;
         owner_q   <= 1'b0;
         we_q      <= 1'b0;
         cnt_q     <= '0;
         mem_a_q   <= '0;
         mem_din_q <= '0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         done0_q   <= 1'b0;
         done1_q   <= 1'b0;
         err0_q    <= 1'b0;
         err1_q    <= 1'b0;
         mem_rd_q  <= 1'b0;
         mem_wr_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         owner_q   <= owner_d;
         we_q      <= we_d;
         cnt_q     <= cnt_d;
         mem_a_q   <= mem_a_d;
         mem_din_q <= mem_din_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         done0_q   <= done0_d;
         done1_q   <= done1_d;
         err0_q    <= err0_d;
         err1_q    <= err1_d;
         mem_rd_q  <= mem_rd_d;
         mem_wr_q  <= mem_wr_d;
      end
   end

   assign gnt0    = gnt0_q;
   assign gnt1    = gnt1_q;
   assign done0   = done0_q;
   assign done1   = done1_q;
   assign err0    = err0_q;
   assign err1    = err1_q;
   assign rdata0  = rdata0_q;
   assign rdata1  = rdata1_q;
   assign mem_rd  = mem_rd_q;
   assign mem_wr  = mem_wr_q;
   assign mem_a   = mem_a_q;
   assign mem_din = mem_din_q;
   assign busy    = (state_q != StIdle);

endmodule
